// File: rtl/hack_boot_loader.sv
// hack_boot_loader
//   Power-up / on-demand program loader for the Hack computer. Holds the CPU
//   in reset, receives a big-endian image (16-bit word count N, then N 16-bit
//   instructions) from a byte source, writes each word into the instruction
//   store, then releases the CPU.
//
// Ports
//   clk, reset        system clock, synchronous active-low reset
//   load_start        one-cycle pulse that begins a (re)load
//   rx_valid/rx_data  byte source; a byte moves when rx_valid & rx_ready
//   rx_ready          loader can take a byte this cycle
//   rom_we/addr/wdata instruction-store write port, one pulse per word
//   cpu_reset         active-high CPU reset, low only while the image runs
//   busy              load in progress
//   done              CPU is running a successfully loaded image
//   err               sticky: oversize image or mid-load timeout
//
// State table
//   state   | meaning
//   IDLE    | CPU held in reset, waiting for load_start
//   LEN_HI  | waiting for word-count high byte (no timeout here)
//   LEN_LO  | waiting for word-count low byte
//   DATA_HI | waiting for instruction high byte
//   DATA_LO | waiting for instruction low byte
//   WRITE   | one-cycle store write of the assembled word
//   RUN     | image loaded, CPU released
//
// Every output is a register loaded from the next-state decode, so each
// output reflects the state the FSM occupies during that same cycle.
module hack_boot_loader #(
  parameter int ADDR_W      = 15,
  parameter int MAX_WORDS   = 32768,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Down-counter only ever holds values up to TIMEOUT_CYC-1.
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, RUN
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      len;
  logic [7:0]       hi_byte;
  logic [15:0]      cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic        accept;
  logic        tmo_run;
  logic        tmo_fire;
  logic        err_set;
  logic        err_clr;
  logic        ready_nxt;
  logic [15:0] len_full;

  assign accept   = rx_valid & rx_ready;
  assign len_full = {len[15:8], rx_data};
  assign tmo_run  = (state == LEN_LO) || (state == DATA_HI) || (state == DATA_LO);
  // Terminal count: the counter was reloaded with TIMEOUT_CYC-1 on the last
  // accept, so reaching zero on an idle edge marks the TIMEOUT_CYC-th idle cycle.
  assign tmo_fire = (TIMEOUT_CYC > 0) && tmo_run && !accept && (tmo_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (load_start) begin
          state_nxt = LEN_HI;
          err_clr   = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0) begin
            state_nxt = RUN;
          end else if ({1'b0, len_full} > MAX_LEN) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
          end else begin
            state_nxt = DATA_HI;
          end
        end else if (tmo_fire) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      DATA_HI: begin
        if (accept) begin
          state_nxt = DATA_LO;
        end else if (tmo_fire) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      DATA_LO: begin
        if (accept) begin
          state_nxt = WRITE;
        end else if (tmo_fire) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end
      end
      WRITE: begin
        state_nxt = (cnt == len - 16'd1) ? RUN : DATA_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_nxt = (state_nxt == LEN_HI) || (state_nxt == LEN_LO) ||
                     (state_nxt == DATA_HI) || (state_nxt == DATA_LO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_ready  <= 1'b0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len       <= '0;
      hi_byte   <= '0;
      cnt       <= '0;
      tmo_cnt   <= '0;
    end else begin
      rx_ready  <= ready_nxt;
      busy      <= ready_nxt || (state_nxt == WRITE);
      rom_we    <= (state_nxt == WRITE);
      cpu_reset <= (state_nxt != RUN);
      done      <= (state_nxt == RUN);

      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;

      if (accept || err_clr)             tmo_cnt <= TMO_RELOAD;
      else if (tmo_run && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

      if (accept && state == LEN_HI) len[15:8] <= rx_data;
      if (accept && state == LEN_LO) begin
        len[7:0] <= rx_data;
        cnt      <= '0;
      end
      if (accept && state == DATA_HI) hi_byte <= rx_data;
      if (accept && state == DATA_LO) begin
        rom_addr  <= ADDR_W'(cnt);
        rom_wdata <= {hi_byte, rx_data};
      end
      if (state == WRITE && state_nxt == DATA_HI) cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Bench for hack_boot_loader (MAX_WORDS=4, TIMEOUT_CYC=10). A byte-stream
// level model predicts every output each cycle; directed scenarios add
// hand-computed literal checks.
module tb_hack_boot_loader;
  localparam int ADDR_W = 15;
  localparam int MAXW   = 4;
  localparam int TMO    = 10;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              reset, load_start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, rom_we, cpu_reset, busy, done, err;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hack_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  // Model: mode 0 = CPU held idle, 1 = loading, 2 = running.
  int          m_mode = 0, m_nb = 0, m_len = 0, m_words = 0, m_idle = 0, m_addr = 0;
  bit          m_wpend = 0, m_err = 0, started = 0;
  logic [7:0]  m_hi = '0;
  logic [15:0] m_wdata = '0;

  always @(posedge clk) begin
    if (!reset) begin
      started = 1;
      m_mode = 0; m_nb = 0; m_len = 0; m_words = 0; m_idle = 0;
      m_wpend = 0; m_err = 0; m_addr = 0; m_wdata = '0;
    end else if (m_mode == 1) begin
      if (m_wpend) begin
        m_wpend = 0;
        m_words++;
        if (m_words == m_len) m_mode = 2;
      end else if (rx_valid) begin
        m_idle = 0;
        if (m_nb == 0) begin
          m_len = int'(rx_data) << 8;
        end else if (m_nb == 1) begin
          m_len = m_len | int'(rx_data);
          if (m_len == 0) m_mode = 2;
          else if (m_len > MAXW) begin m_mode = 0; m_err = 1; end
        end else if (m_nb % 2 == 0) begin
          m_hi = rx_data;
        end else begin
          m_wpend = 1;
          m_addr  = m_words;
          m_wdata = {m_hi, rx_data};
        end
        m_nb++;
      end else if (m_nb > 0 && TMO > 0) begin
        m_idle++;
        if (m_idle == TMO) begin m_mode = 0; m_err = 1; end
      end
    end else if (load_start) begin
      m_mode = 1; m_err = 0; m_nb = 0; m_words = 0; m_idle = 0;
    end
  end

  logic [ADDR_W-1:0] wr_a[$];
  logic [15:0]       wr_d[$];

  always @(negedge clk) begin
    logic [6+ADDR_W+16-1:0] e, a;
    if (started) begin
      e = {(m_mode == 1) && !m_wpend, m_wpend, m_mode != 2, m_mode == 1, m_mode == 2, m_err,
           ADDR_W'(m_addr), m_wdata};
      a = {rx_ready, rom_we, cpu_reset, busy, done, err, rom_addr, rom_wdata};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_outputs @%0t: got %h want %h (ready,we,cpu_rst,busy,done,err,addr,data)",
                 $time, a, e);
      end
      if (rom_we === 1'b1) begin
        wr_a.push_back(rom_addr);
        wr_d.push_back(rom_wdata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rx_ready === 1'b1) begin
        @(posedge clk);
        ok = 1;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h not accepted, want accept within 20 cycles", b);
    end
  endtask

  task automatic send_q(input byte_q_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  initial begin
    byte_q_t q;
    int n;
    reset = 1'b0; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_rom_we", rom_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_stays_busy", busy, 0);
    check("idle_stays_ready", rx_ready, 0);

    // two-word image, rx_valid held high
    wr_a.delete(); wr_d.delete();
    pulse_start();
    q = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
    send_q(q);
    check("w2_we_after_lo", rom_we, 1);
    check("w2_addr", rom_addr, 1);
    check("w2_data", rom_wdata, 16'h1234);
    check("w2_cpu_rst_hold", cpu_reset, 1);
    @(negedge clk);
    check("w2_cpu_rst_fall", cpu_reset, 0);
    check("w2_done", done, 1);
    check("w2_we_off", rom_we, 0);
    #1;
    check("w2_count", wr_a.size(), 2);
    check("w2_a0", wr_a[0], 0);
    check("w2_d0", wr_d[0], 16'hABCD);
    check("w2_a1", wr_a[1], 1);
    check("w2_d1", wr_d[1], 16'h1234);
    rx_valid = 1'b0;
    @(negedge clk);

    // zero-length image, reload out of RUN
    wr_a.delete(); wr_d.delete();
    pulse_start();
    check("reload_cpu_rst", cpu_reset, 1);
    check("reload_done_clr", done, 0);
    check("reload_busy", busy, 1);
    q = '{8'h00, 8'h00};
    send_q(q);
    check("n0_cpu_rst", cpu_reset, 0);
    check("n0_done", done, 1);
    #1;
    check("n0_no_write", wr_a.size(), 0);
    rx_valid = 1'b0;
    @(negedge clk);

    // oversize image
    pulse_start();
    q = '{8'h00, 8'h05};
    send_q(q);
    check("big_err", err, 1);
    check("big_cpu_rst", cpu_reset, 1);
    check("big_busy", busy, 0);
    check("big_ready", rx_ready, 0);
    #1;
    check("big_no_write", wr_a.size(), 0);
    rx_valid = 1'b0;
    @(negedge clk);
    pulse_start();
    check("big_err_clr", err, 0);
    check("big_restart_ready", rx_ready, 1);

    // image of exactly MAX_WORDS
    wr_a.delete(); wr_d.delete();
    q = '{8'h00, 8'h04, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'hFF, 8'hFF};
    send_q(q);
    @(negedge clk);
    #1;
    check("max_count", wr_a.size(), 4);
    check("max_last_addr", wr_a[3], 3);
    check("max_last_data", wr_d[3], 16'hFFFF);
    check("max_done", done, 1);
    rx_valid = 1'b0;
    @(negedge clk);

    // mid-load timeout
    pulse_start();
    q = '{8'h00, 8'h03, 8'hAB};
    send_q(q);
    rx_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (err === 1'b1) break;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_busy", busy, 0);
    check("tmo_cpu_rst", cpu_reset, 1);

    // load_start while busy is ignored
    wr_a.delete(); wr_d.delete();
    pulse_start();
    q = '{8'h00, 8'h02, 8'h11, 8'h22};
    send_q(q);
    rx_valid = 1'b0;
    @(negedge clk);
    pulse_start();
    check("busy_start_busy", busy, 1);
    q = '{8'h33, 8'h44};
    send_q(q);
    @(negedge clk);
    #1;
    check("busy_start_count", wr_a.size(), 2);
    check("busy_start_d1", wr_d[1], 16'h3344);
    check("busy_start_done", done, 1);
    rx_valid = 1'b0;
    @(negedge clk);

    // reset mid-data
    pulse_start();
    q = '{8'h00, 8'h02, 8'hAA};
    send_q(q);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_cpu_rst", cpu_reset, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", rx_ready, 0);
    check("mid_rst_addr", rom_addr, 0);
    check("mid_rst_data", rom_wdata, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_idle", busy, 0);

    // load_start with a stray valid byte present
    wr_a.delete(); wr_d.delete();
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    pulse_start();
    q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
    send_q(q);
    @(negedge clk);
    #1;
    check("stray_count", wr_a.size(), 1);
    check("stray_d0", wr_d[0], 16'hBEEF);
    check("stray_done", done, 1);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
